// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port, synchronous-read video RAM between the VGA tile
// scan-out and the CPU data port. VGA fetches always win arbitration; CPU
// accesses use a ready/valid handshake with bounded latency.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   vga_addr / vga_data  tile word address in, registered tile word out
//   cpu_req/we/addr/wdata  CPU request (ready/valid), write flag, address, data
//   cpu_ready            request accepted when cpu_req && cpu_ready
//   cpu_rdata/rvalid     read data with a one-cycle valid pulse
//   ram_addr/we/wdata    RAM request side
//   ram_rdata            RAM read data, valid the cycle after address issue
//
// Build option:
//   VRAM_WBUF_EN  adds a one-entry posted write buffer so CPU writes can be
//                 accepted in any state while the buffer is empty.
// -----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 300
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VGA_RD = 2'd1,
    CPU_RD = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  // Words at or beyond DEPTH are outside the tile map.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    in_range = ({1'b0, a} < DEPTH_C);
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   last_vaddr_q, last_vaddr_d;
  logic                vga_force_q, vga_force_d;
  logic                vga_oor_q, vga_oor_d;
  logic                cpu_oor_q, cpu_oor_d;
  logic [DATA_W-1:0]   vga_data_q, vga_data_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;

  logic vga_need_s, idle_s, issue_vga_s;
  logic wr_ok_s, rd_ok_s, wr_direct_s, rd_acc_s;

`ifdef VRAM_WBUF_EN
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              drain_s, wr_post_s;
`endif

  // Arbitration decisions shared by the next-state and output processes.
  always_comb begin
    vga_need_s  = vga_force_q || (vga_addr != last_vaddr_q);
    idle_s      = (state_q == IDLE) && !reset;
    issue_vga_s = idle_s && vga_need_s;
`ifdef VRAM_WBUF_EN
    // Reads wait for an empty buffer so they never overtake a posted write.
    rd_ok_s     = idle_s && !vga_need_s && !wb_valid_q;
    wr_ok_s     = !reset && !wb_valid_q;
    drain_s     = idle_s && !vga_need_s && wb_valid_q;
    // A write that can go straight to RAM bypasses the buffer.
    wr_direct_s = cpu_req && cpu_we && rd_ok_s;
    wr_post_s   = cpu_req && cpu_we && wr_ok_s && !rd_ok_s;
`else
    rd_ok_s     = idle_s && !vga_need_s;
    wr_ok_s     = idle_s && !vga_need_s;
    wr_direct_s = cpu_req && cpu_we && wr_ok_s;
`endif
    rd_acc_s    = cpu_req && !cpu_we && rd_ok_s;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_vaddr_q <= {ADDR_W{1'b0}};
      vga_force_q  <= 1'b1;
      vga_oor_q    <= 1'b0;
      cpu_oor_q    <= 1'b0;
      vga_data_q   <= {DATA_W{1'b0}};
      cpu_rdata_q  <= {DATA_W{1'b0}};
      cpu_rvalid_q <= 1'b0;
`ifdef VRAM_WBUF_EN
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= {ADDR_W{1'b0}};
      wb_data_q    <= {DATA_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      last_vaddr_q <= last_vaddr_d;
      vga_force_q  <= vga_force_d;
      vga_oor_q    <= vga_oor_d;
      cpu_oor_q    <= cpu_oor_d;
      vga_data_q   <= vga_data_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
`ifdef VRAM_WBUF_EN
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
`endif
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_d      = state_q;
    last_vaddr_d = last_vaddr_q;
    vga_force_d  = vga_force_q;
    vga_oor_d    = vga_oor_q;
    cpu_oor_d    = cpu_oor_q;
    vga_data_d   = vga_data_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_rvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_vga_s) begin
          state_d      = VGA_RD;
          last_vaddr_d = vga_addr;
          vga_force_d  = 1'b0;
          vga_oor_d    = !in_range(vga_addr);
        end else if (rd_acc_s) begin
          state_d   = CPU_RD;
          cpu_oor_d = !in_range(cpu_addr);
        end else begin
          state_d = IDLE;
        end
      end
      VGA_RD: begin
        // A vga_addr change during this fetch is caught by the mismatch in IDLE.
        vga_data_d = vga_oor_q ? {DATA_W{1'b0}} : ram_rdata;
        state_d    = IDLE;
      end
      CPU_RD: begin
        cpu_rdata_d  = cpu_oor_q ? {DATA_W{1'b0}} : ram_rdata;
        cpu_rvalid_d = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef VRAM_WBUF_EN
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (drain_s) begin
      wb_valid_d = 1'b0;
    end else if (wr_post_s) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = cpu_addr;
      wb_data_d  = cpu_wdata;
    end else begin
      wb_valid_d = wb_valid_q;
    end
`endif
  end

  // RAM request and handshake outputs.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_we    = 1'b0;
    ram_wdata = cpu_wdata;
    cpu_ready = cpu_we ? wr_ok_s : rd_ok_s;
    if (issue_vga_s) begin
      ram_addr = vga_addr;
`ifdef VRAM_WBUF_EN
    end else if (drain_s) begin
      ram_addr  = wb_addr_q;
      ram_we    = in_range(wb_addr_q);
      ram_wdata = wb_data_q;
`endif
    end else if (wr_direct_s) begin
      ram_we = in_range(cpu_addr);
    end else begin
      ram_we = 1'b0;
    end
  end

  assign vga_data   = vga_data_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Self-checking bench: behavioural synchronous-read RAM, a reference memory
// image updated on accepted CPU writes, and a queue of expected read results
// (data and arrival cycle) pushed at read accept and popped on cpu_rvalid.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int NW = 300;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_data;
  logic          cpu_req, cpu_we, cpu_ready, cpu_rvalid;
  logic [AW-1:0] cpu_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
  logic          ram_we;
  logic          init_mem;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [DW-1:0] mem     [0:511];
  logic [DW-1:0] ref_mem [0:511];
  logic [31:0]   exp_q[$];
  int            exp_cyc_q[$];
  int            oor_we_cnt = 0;
  logic [AW-1:0] last_we_addr;
  logic [DW-1:0] last_we_data;
  int            last_we_cyc = -1;
  int            acc_cyc = 0;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(NW)) dut (
    .clk(clk), .reset(reset),
    .vga_addr(vga_addr), .vga_data(vga_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int a);
    return (a < NW) ? ref_mem[a] : 32'h0;
  endfunction

  // Monitor: scoreboard pop on rvalid, write log, push on read accept.
  always @(negedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 512; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    if (cpu_rvalid) begin
      if (exp_q.size() == 0) begin
        chk_eq("rvalid_spurious", 32'd1, 32'd0);
      end else begin
        chk_eq("cpu_rdata", cpu_rdata, exp_q.pop_front());
        chk_eq("rvalid_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
      end
    end
    if (ram_we) begin
      last_we_addr = ram_addr;
      last_we_data = ram_wdata;
      last_we_cyc  = cyc;
      if (int'(ram_addr) >= NW) oor_we_cnt++;
    end
    if (!reset && cpu_req && cpu_ready) begin
      acc_cyc = cyc;
      if (cpu_we) begin
        if (int'(cpu_addr) < NW) ref_mem[cpu_addr] = cpu_wdata;
      end else begin
        exp_q.push_back(exp_word(int'(cpu_addr)));
        exp_cyc_q.push_back(cyc + 2);
      end
    end
  end

  // Drive one CPU request (called #1 after a rising edge); returns cycles stalled.
  task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int waited);
    bit done;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    waited = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (cpu_ready) begin
        done = 1'b1;
      end else if (waited >= 20) begin
        chk_eq("cpu_accept_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end else begin
        waited++;
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait a bounded number of cycles for vga_data to reach the expected word.
  task automatic wait_vga(input string tag, input logic [31:0] exp, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (vga_data !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk_eq(tag, vga_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, req_cyc, oor_before;
    reset = 1'b1; init_mem = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; vga_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("ready_in_reset", 32'(cpu_ready), 32'd0);
    chk_eq("vga_data_reset", vga_data, 32'h0);
    chk_eq("rdata_reset", cpu_rdata, 32'h0);
    chk_eq("rvalid_reset", 32'(cpu_rvalid), 32'd0);
    init_mem = 1'b0; cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset then idle: forced fetch of word 0 on the first cycle.
    @(negedge clk);
    chk_eq("first_fetch_addr", 32'(ram_addr), 32'd0);
    chk_eq("first_fetch_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk_eq("vga_word0", vga_data, 32'hA500_0000);
    @(posedge clk); #1;

    // CPU write then read of address 5.
    cpu_op(1'b1, 9'd5, 32'hDEAD_BEEF, w);
    chk_eq("wr5_wait", 32'(w), 32'd0);
    chk_eq("wr5_ram_addr", 32'(last_we_addr), 32'd5);
    chk_eq("wr5_ram_wdata", last_we_data, 32'hDEAD_BEEF);
    chk_eq("wr5_same_cycle", 32'(last_we_cyc), 32'(acc_cyc));
    cpu_op(1'b0, 9'd5, 32'h0, w);
    chk_eq("rd5_wait", 32'(w), 32'd0);
    idle_cycles(3);

    // Back-to-back writes at one per cycle, then read them back.
    for (int i = 0; i < 4; i++) begin
      cpu_op(1'b1, 9'(40 + i), 32'h1111_0000 + 32'(i), w);
      chk_eq("b2b_wr_wait", 32'(w), 32'd0);
    end
    for (int i = 0; i < 4; i++) cpu_op(1'b0, 9'(40 + i), 32'h0, w);
    idle_cycles(3);

    // Collision: VGA change and CPU read in the same cycle.
    vga_addr = 9'd20;
    wait_vga("vga_20", exp_word(20), 4);
    vga_addr = 9'd21;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'd7;
    req_cyc = cyc;
    @(negedge clk);
    chk_eq("collision_ram_addr", 32'(ram_addr), 32'd21);
    chk_eq("collision_ready", 32'(cpu_ready), 32'd0);
    @(posedge clk); #1;
    cpu_op(1'b0, 9'd7, 32'h0, w);
    chk_eq("collision_accept_delay", 32'(acc_cyc - req_cyc), 32'd2);
    wait_vga("vga_21", exp_word(21), 4);

    // Mid-fetch address change.
    vga_addr = 9'd3;
    @(posedge clk); #1;
    vga_addr = 9'd4;
    @(posedge clk); #1;
    @(negedge clk);
    chk_eq("midfetch_old", vga_data, exp_word(3));
    chk_eq("refetch_addr", 32'(ram_addr), 32'd4);
    @(posedge clk); #1;
    wait_vga("midfetch_new", exp_word(4), 3);

    // Out of range accesses.
    oor_before = oor_we_cnt;
    cpu_op(1'b1, 9'd300, 32'h1, w);
    chk_eq("oor_wr_wait", 32'(w), 32'd0);
    chk_eq("oor_no_we", 32'(oor_we_cnt), 32'(oor_before));
    cpu_op(1'b0, 9'd300, 32'h0, w);
    idle_cycles(3);
    vga_addr = 9'd310;
    wait_vga("vga_oor", 32'h0, 4);
    vga_addr = 9'd0;
    wait_vga("vga_back0", exp_word(0), 4);

    // Reset during CPU_RD abandons the read and re-forces a VGA fetch.
    cpu_op(1'b0, 9'd9, 32'h0, w);
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk_eq("vga_data_midreset", vga_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_vga("vga_after_reset", exp_word(0), 4);
    idle_cycles(2);

`ifdef VRAM_WBUF_EN
    // Posted write during VGA_RD, then a read of the same address.
    vga_addr = 9'd50;
    @(posedge clk); #1;
    cpu_op(1'b1, 9'd10, 32'hCAFE_F00D, w);
    chk_eq("wbuf_wr_wait", 32'(w), 32'd0);
    cpu_op(1'b0, 9'd10, 32'h0, w);
    chk_eq("wbuf_rd_stalled", 32'(w > 0), 32'd1);
    idle_cycles(3);
`endif

    idle_cycles(4);
    chk_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
